riscv_trace_buffer: RTL and testbench

Commit-trace capture stage downstream of the `riscv` core. Each cycle it samples the core's register-writeback and data-memory observation outputs, packs every valid event into a timestamped record, and queues the records in a FIFO. The FIFO drains over a ready/valid port to a testbench monitor or host link. Overflow is counted, never silently lost.

---
 rtl/riscv_trace_buffer.sv | 117 +++++++++++
 tb/tb_riscv_trace_buffer.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/riscv_trace_buffer.sv
// Commit-trace capture: packs reg-writeback / mem-write / mem-read events into stamped records and queues them.
// Records reach the head one cycle after capture; a cycle's events are dropped as a group when space is short (counted, never partial).
module riscv_trace_buffer #(
    parameter int DEPTH   = 16,
    parameter int STAMP_W = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       reg_write_sig,
    input  logic [4:0]                 reg_num,
    input  logic [31:0]                reg_data,
    input  logic                       wr,
    input  logic                       rd,
    input  logic [8:0]                 addr,
    input  logic [31:0]                wr_data,
    input  logic [31:0]                rd_data,
    input  logic                       flush,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [STAMP_W+42:0]        out_data,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overflow,
    output logic [15:0]                drop_count
);
    localparam int AW    = $clog2(DEPTH);
    localparam int REC_W = STAMP_W + 43;

    logic [REC_W-1:0]   mem_q [DEPTH];
    logic [AW-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]        count_q, count_d;
    logic [STAMP_W-1:0] stamp_q;
    logic               overflow_q, overflow_d;
    logic [15:0]        drop_q, drop_d;

    logic [2:0]         ev_vld;
    logic [REC_W-1:0]   rec [3];
    logic [AW-1:0]      pos [3];
    logic [1:0]         n_ev;
    logic [AW:0]        free;
    logic [16:0]        drop_sum;
    logic               accept, pop;

    // Slot order within a cycle is fixed: register write, memory write, memory read.
    assign ev_vld = {rd, wr, reg_write_sig && (reg_num != 5'd0)};
    assign n_ev   = {1'b0, ev_vld[0]} + {1'b0, ev_vld[1]} + {1'b0, ev_vld[2]};
    assign free   = (AW+1)'(DEPTH) - count_q;
    assign accept = !flush && (n_ev != 2'd0) && ({{(AW-1){1'b0}}, n_ev} <= free);
    assign pop    = out_valid && out_ready && !flush;
    assign drop_sum = {1'b0, drop_q} + 17'(n_ev);

    always_comb begin
        rec[0] = {2'b00, stamp_q, {4'b0000, reg_num}, reg_data};
        rec[1] = {2'b01, stamp_q, addr, wr_data};
        rec[2] = {2'b10, stamp_q, addr, rd_data};
        pos[0] = wr_ptr_q;
        pos[1] = wr_ptr_q + AW'(ev_vld[0]);
        pos[2] = pos[1] + AW'(ev_vld[1]);
    end

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        drop_d     = drop_q;
        if (flush) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            overflow_d = 1'b0;
            drop_d     = '0;
        end else begin
            if (accept) begin
                wr_ptr_d = wr_ptr_q + AW'(n_ev);
                count_d  = count_q + (AW+1)'(n_ev);
            end else if (n_ev != 2'd0) begin
                overflow_d = 1'b1;
                drop_d     = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
                count_d  = count_d - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            stamp_q    <= '0;
            overflow_q <= 1'b0;
            drop_q     <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            stamp_q    <= stamp_q + 1'b1;
            overflow_q <= overflow_d;
            drop_q     <= drop_d;
        end
    end

    // Storage carries no reset; validity is tracked solely by count_q.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (accept && ev_vld[i]) mem_q[pos[i]] <= rec[i];
        end
    end

    assign out_valid  = (count_q != '0);
    assign out_data   = out_valid ? mem_q[rd_ptr_q] : '0;
    assign count      = count_q;
    assign overflow   = overflow_q;
    assign drop_count = drop_q;
endmodule

// File: tb/tb_riscv_trace_buffer.sv
// Directed bench for riscv_trace_buffer: one task per scenario, inline comparisons.
module tb_riscv_trace_buffer;
    logic        clk, reset, reg_write_sig, wr, rd, flush, out_ready, out_valid, overflow;
    logic [4:0]  reg_num;
    logic [31:0] reg_data, wr_data, rd_data;
    logic [8:0]  addr;
    logic [58:0] out_data;
    logic [4:0]  count;
    logic [15:0] drop_count;

    int checks   = 0;
    int failures = 0;
    int stamp_m  = 0;

    riscv_trace_buffer #(.DEPTH(16), .STAMP_W(16)) dut (
        .clk(clk), .reset(reset), .reg_write_sig(reg_write_sig), .reg_num(reg_num),
        .reg_data(reg_data), .wr(wr), .rd(rd), .addr(addr), .wr_data(wr_data),
        .rd_data(rd_data), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .count(count), .overflow(overflow), .drop_count(drop_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    function automatic logic [58:0] mkrec(input logic [1:0] k, input int st,
                                          input logic [8:0] tag, input logic [31:0] d);
        logic [15:0] s;
        s = st[15:0];
        return {k, s, tag, d};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        if (!reset) stamp_m++;
    endtask

    task automatic idle();
        reg_write_sig = 0; wr = 0; rd = 0; flush = 0;
        reg_num = 0; reg_data = 0; addr = 0; wr_data = 0; rd_data = 0;
    endtask

    task automatic test_reset();
        idle(); out_ready = 0; reset = 1;
        repeat (2) @(posedge clk);
        #1 reset = 0; stamp_m = 0;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
        checks++; if (count !== 5'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", count); end
        checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL reset_overflow got=%b exp=0", overflow); end
        checks++; if (drop_count !== 16'd0) begin failures++; $display("FAIL reset_drop got=%0d exp=0", drop_count); end
        checks++; if (out_data !== 59'd0) begin failures++; $display("FAIL reset_data got=%h exp=0", out_data); end
    endtask

    task automatic test_single();
        logic [58:0] exp;
        while (stamp_m < 3) tick();
        reg_write_sig = 1; reg_num = 5; reg_data = 32'hDEADBEEF; out_ready = 1;
        exp = mkrec(2'b00, 3, 9'd5, 32'hDEADBEEF);
        tick(); idle();
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL single_valid got=%b exp=1", out_valid); end
        checks++; if (out_data !== exp) begin failures++; $display("FAIL single_data got=%h exp=%h", out_data, exp); end
        checks++; if (count !== 5'd1) begin failures++; $display("FAIL single_count got=%0d exp=1", count); end
        tick(); out_ready = 0;
        checks++; if (count !== 5'd0) begin failures++; $display("FAIL single_drain got=%0d exp=0", count); end
    endtask

    task automatic test_multi();
        logic [58:0] exp [3];
        out_ready = 0;
        reg_write_sig = 1; reg_num = 7; reg_data = 32'h1;
        wr = 1; rd = 1; addr = 9'h1F; wr_data = 32'h55; rd_data = 32'hAA;
        exp[0] = mkrec(2'b00, stamp_m, 9'd7, 32'h1);
        exp[1] = mkrec(2'b01, stamp_m, 9'h1F, 32'h55);
        exp[2] = mkrec(2'b10, stamp_m, 9'h1F, 32'hAA);
        tick(); idle();
        checks++; if (count !== 5'd3) begin failures++; $display("FAIL multi_count got=%0d exp=3", count); end
        for (int k = 0; k < 3; k++) begin
            checks++; if (out_data !== exp[k]) begin failures++; $display("FAIL multi_order%0d got=%h exp=%h", k, out_data, exp[k]); end
            out_ready = 1; tick(); out_ready = 0;
        end
        reg_write_sig = 1; reg_num = 0; reg_data = 32'h1234;
        tick(); idle();
        checks++; if (count !== 5'd0) begin failures++; $display("FAIL x0_count got=%0d exp=0", count); end
    endtask

    task automatic test_overflow_flush();
        logic [58:0] head;
        out_ready = 0;
        head = mkrec(2'b00, stamp_m, 9'd1, 32'd0);
        for (int i = 0; i < 15; i++) begin
            reg_write_sig = 1; reg_num = 1; reg_data = i; tick();
        end
        idle();
        checks++; if (count !== 5'd15) begin failures++; $display("FAIL fill_count got=%0d exp=15", count); end
        wr = 1; rd = 1; addr = 9'h2; wr_data = 32'h77; rd_data = 32'h88;
        tick(); idle();
        checks++; if (count !== 5'd15) begin failures++; $display("FAIL ovf_count got=%0d exp=15", count); end
        checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL ovf_flag got=%b exp=1", overflow); end
        checks++; if (drop_count !== 16'd2) begin failures++; $display("FAIL ovf_drop got=%0d exp=2", drop_count); end
        reg_write_sig = 1; reg_num = 1; reg_data = 32'd15;
        tick(); idle();
        checks++; if (count !== 5'd16) begin failures++; $display("FAIL full_count got=%0d exp=16", count); end
        checks++; if (out_data !== head) begin failures++; $display("FAIL full_head got=%h exp=%h", out_data, head); end
        reg_write_sig = 1; reg_num = 3; reg_data = 32'd99; out_ready = 1;
        tick(); idle(); out_ready = 0;
        checks++; if (count !== 5'd15) begin failures++; $display("FAIL nocredit_count got=%0d exp=15", count); end
        checks++; if (drop_count !== 16'd3) begin failures++; $display("FAIL nocredit_drop got=%0d exp=3", drop_count); end
        checks++; if (out_data[31:0] !== 32'd1) begin failures++; $display("FAIL nocredit_head got=%0d exp=1", out_data[31:0]); end
        out_ready = 1; repeat (6) tick(); out_ready = 0;
        checks++; if (count !== 5'd9) begin failures++; $display("FAIL preflush_count got=%0d exp=9", count); end
        flush = 1; out_ready = 1; reg_write_sig = 1; reg_num = 4; reg_data = 32'h4;
        tick(); idle(); out_ready = 0;
        checks++; if (count !== 5'd0) begin failures++; $display("FAIL flush_count got=%0d exp=0", count); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL flush_valid got=%b exp=0", out_valid); end
        checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL flush_overflow got=%b exp=0", overflow); end
        checks++; if (drop_count !== 16'd0) begin failures++; $display("FAIL flush_drop got=%0d exp=0", drop_count); end
        wr = 1; addr = 9'h33; wr_data = 32'd77;
        head = mkrec(2'b01, stamp_m, 9'h33, 32'd77);
        tick(); idle();
        checks++; if (out_data !== head) begin failures++; $display("FAIL flush_stamp got=%h exp=%h", out_data, head); end
        out_ready = 1; tick(); out_ready = 0;
    endtask

    task automatic test_wrap();
        logic [58:0] exp_a [40];
        int sent = 0;
        int recv = 0;
        for (int c = 0; c < 400 && recv < 40; c++) begin
            idle();
            if (sent < 40 && (c % 3) != 2) begin
                reg_write_sig = 1; reg_num = 5'((sent % 31) + 1); reg_data = 32'h1000 + sent;
                exp_a[sent] = mkrec(2'b00, stamp_m, {4'b0000, reg_num}, reg_data);
                sent++;
            end
            out_ready = (c % 2) == 1;
            if (out_valid && out_ready) begin
                checks++; if (out_data !== exp_a[recv]) begin failures++; $display("FAIL wrap_rec%0d got=%h exp=%h", recv, out_data, exp_a[recv]); end
                recv++;
            end
            tick();
        end
        idle(); out_ready = 0;
        checks++; if (recv !== 40) begin failures++; $display("FAIL wrap_total got=%0d exp=40", recv); end
        checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL wrap_overflow got=%b exp=0", overflow); end
    endtask

    task automatic test_async_reset();
        logic [58:0] exp;
        out_ready = 0;
        for (int i = 0; i < 4; i++) begin
            reg_write_sig = 1; reg_num = 9; reg_data = i; tick();
        end
        idle();
        checks++; if (count !== 5'd4) begin failures++; $display("FAIL prereset_count got=%0d exp=4", count); end
        #3 reset = 1;
        #1;
        checks++; if (count !== 5'd0) begin failures++; $display("FAIL async_count got=%0d exp=0", count); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL async_valid got=%b exp=0", out_valid); end
        @(posedge clk);
        #1 reset = 0; stamp_m = 0;
        reg_write_sig = 1; reg_num = 2; reg_data = 32'hCAFE;
        exp = mkrec(2'b00, 0, 9'd2, 32'hCAFE);
        tick(); idle();
        checks++; if (out_data !== exp) begin failures++; $display("FAIL restart_stamp got=%h exp=%h", out_data, exp); end
        checks++; if (count !== 5'd1) begin failures++; $display("FAIL restart_count got=%0d exp=1", count); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_multi();
        test_overflow_flush();
        test_wrap();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
